// File: rtl/clock_pkg.sv
// Shared definitions for the front-panel controller: panel states, field limits
// and buzzer source encodings.
package clock_pkg;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_TIME_HR   = 3'd1,
      ST_TIME_MIN  = 3'd2,
      ST_ALARM_HR  = 3'd3,
      ST_ALARM_MIN = 3'd4,
      ST_TIMER     = 3'd5,
      ST_FORMAT    = 3'd6
   } panel_state_t;

   localparam logic [5:0] HR_MAX  = 6'd23;
   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [3:0] TMR_MIN = 4'd1;
   localparam logic [3:0] TMR_MAX = 4'd15;

   localparam logic [1:0] BUZZ_NONE  = 2'b00;
   localparam logic [1:0] BUZZ_ALARM = 2'b01;
   localparam logic [1:0] BUZZ_TIMER = 2'b10;

   // Increment a 6-bit time field, rolling over to zero past its maximum.
   function automatic logic [5:0] wrap_inc6(input logic [5:0] value, input logic [5:0] max);
      return (value == max) ? 6'd0 : value + 6'd1;
   endfunction

endpackage

// File: rtl/buzzer_arbiter.sv
// Merges the alarm and timer buzzer levels into one speaker drive, with
// per-source mutes that a button press sets while the speaker is sounding.
module buzzer_arbiter
   import clock_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       alarm_buzzer,
   input  logic       timer_buzzer,
   input  logic       any_press,
   output logic       buzzer,
   output logic [1:0] buzz_src,
   output logic       press_consumed
);

   logic       alarm_mute;
   logic       timer_mute;
   logic       alarm_mute_nxt;
   logic       timer_mute_nxt;
   logic [1:0] src_nxt;

   // A mute only survives while its source stays asserted, so a later rise sounds again.
   always_comb begin
      press_consumed = any_press & buzzer;
      alarm_mute_nxt = alarm_buzzer & (alarm_mute | (press_consumed & (buzz_src == BUZZ_ALARM)));
      timer_mute_nxt = timer_buzzer & (timer_mute | (press_consumed & (buzz_src == BUZZ_TIMER)));
      src_nxt        = BUZZ_NONE;
      if (alarm_buzzer && !alarm_mute_nxt)
         src_nxt = BUZZ_ALARM;
      else if (timer_buzzer && !timer_mute_nxt)
         src_nxt = BUZZ_TIMER;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alarm_mute <= 1'b0;
         timer_mute <= 1'b0;
         buzz_src   <= BUZZ_NONE;
         buzzer     <= 1'b0;
      end else begin
         alarm_mute <= alarm_mute_nxt;
         timer_mute <= timer_mute_nxt;
         buzz_src   <= src_nxt;
         buzzer     <= (src_nxt != BUZZ_NONE);
      end
   end

endmodule

// File: rtl/clock_panel_ctrl.sv
// Front-panel controller: turns three button pulses into time-adjust strobes and
// staged/committed alarm, timer and display-format settings for digital_clock.
module clock_panel_ctrl
   import clock_pkg::*;
#(
   parameter int IDLE_TIMEOUT   = 30,
   parameter int ALARM_HR_INIT  = 12,
   parameter int ALARM_MIN_INIT = 1,
   parameter int TIMER_INIT     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_next,
   input  logic       btn_inc,
   input  logic       alarm_buzzer,
   input  logic       timer_buzzer,
   output logic       AM_mode,
   output logic       add_hour,
   output logic       add_minute,
   output logic       set_alarm,
   output logic [5:0] alarm_hr,
   output logic [5:0] alarm_min,
   output logic       set_timer,
   output logic [3:0] timer_minutes,
   output logic       buzzer,
   output logic [1:0] buzz_src,
   output logic [2:0] panel_state
);

   localparam int              CNT_W    = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_TIMEOUT);

   panel_state_t     state;
   logic [5:0]       stage_hr;
   logic [5:0]       stage_min;
   logic [3:0]       stage_tmr;
   logic [CNT_W-1:0] idle_cnt;
   logic             any_press;
   logic             press_consumed;
   logic             mode_p;
   logic             next_p;
   logic             inc_p;

   // A press that silences the speaker is swallowed; otherwise mode beats next beats inc.
   assign any_press   = btn_mode | btn_next | btn_inc;
   assign mode_p      = btn_mode & ~press_consumed;
   assign next_p      = btn_next & ~btn_mode & ~press_consumed;
   assign inc_p       = btn_inc & ~btn_mode & ~btn_next & ~press_consumed;
   assign panel_state = state;

   buzzer_arbiter u_buzzer_arbiter (
      .clk            (clk),
      .reset          (reset),
      .alarm_buzzer   (alarm_buzzer),
      .timer_buzzer   (timer_buzzer),
      .any_press      (any_press),
      .buzzer         (buzzer),
      .buzz_src       (buzz_src),
      .press_consumed (press_consumed)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_RUN;
         AM_mode       <= 1'b1;
         add_hour      <= 1'b0;
         add_minute    <= 1'b0;
         set_alarm     <= 1'b0;
         set_timer     <= 1'b0;
         alarm_hr      <= 6'(ALARM_HR_INIT);
         alarm_min     <= 6'(ALARM_MIN_INIT);
         timer_minutes <= 4'(TIMER_INIT);
         stage_hr      <= 6'(ALARM_HR_INIT);
         stage_min     <= 6'(ALARM_MIN_INIT);
         stage_tmr     <= 4'(TIMER_INIT);
         idle_cnt      <= '0;
      end else begin
         add_hour   <= 1'b0;
         add_minute <= 1'b0;
         set_alarm  <= 1'b0;
         set_timer  <= 1'b0;

         // The counter saturates at the timeout so the abort below fires exactly once.
         if (any_press || state == ST_RUN)
            idle_cnt <= '0;
         else if (idle_cnt != IDLE_MAX)
            idle_cnt <= idle_cnt + 1'b1;

         if (mode_p) begin
            case (state)
               ST_RUN: state <= ST_TIME_HR;
               ST_TIME_HR, ST_TIME_MIN: begin
                  stage_hr  <= alarm_hr;
                  stage_min <= alarm_min;
                  state     <= ST_ALARM_HR;
               end
               ST_ALARM_HR, ST_ALARM_MIN: begin
                  alarm_hr  <= stage_hr;
                  alarm_min <= stage_min;
                  set_alarm <= 1'b1;
                  stage_tmr <= timer_minutes;
                  state     <= ST_TIMER;
               end
               ST_TIMER: begin
                  timer_minutes <= stage_tmr;
                  set_timer     <= 1'b1;
                  state         <= ST_FORMAT;
               end
               default: state <= ST_RUN;
            endcase
         end else if (next_p) begin
            case (state)
               ST_TIME_HR:   state <= ST_TIME_MIN;
               ST_TIME_MIN:  state <= ST_TIME_HR;
               ST_ALARM_HR:  state <= ST_ALARM_MIN;
               ST_ALARM_MIN: state <= ST_ALARM_HR;
               default:      state <= state;
            endcase
         end else if (inc_p) begin
            case (state)
               ST_TIME_HR:   add_hour   <= 1'b1;
               ST_TIME_MIN:  add_minute <= 1'b1;
               ST_ALARM_HR:  stage_hr   <= wrap_inc6(stage_hr, HR_MAX);
               ST_ALARM_MIN: stage_min  <= wrap_inc6(stage_min, MIN_MAX);
               ST_TIMER:     stage_tmr  <= (stage_tmr == TMR_MAX) ? TMR_MIN : stage_tmr + 4'd1;
               ST_FORMAT:    AM_mode    <= ~AM_mode;
               default:      AM_mode    <= AM_mode;
            endcase
         end else if (!any_press && state != ST_RUN && idle_cnt == IDLE_MAX) begin
            state <= ST_RUN;
         end
      end
   end

endmodule
